// File: rtl/ifetch_if.sv
// Fetch-stage bundle: PC/stall to next-PC logic, imem request/response, decode queue head.
// Latency: wiring only.
// Backpressure: carries inst_ready from decode and pc_stall to the PC register.
//
// Ports (master = ifetch, slave = surrounding pipeline and memory):
//   pc, pc_stall                        PC register side
//   imem_req/addr/gnt/rvalid/rdata      instruction memory side
//   flush                               branch/jump redirect
//   inst_valid/inst/inst_pc/inst_err    decode side, with inst_ready returned
interface ifetch_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] pc;
    logic                 pc_stall;
    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [WORD_SIZE-1:0] imem_rdata;
    logic                 flush;
    logic                 inst_valid;
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] inst_pc;
    logic                 inst_err;
    logic                 inst_ready;

    modport master (
        input  pc, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
        output pc_stall, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_err
    );

    modport slave (
        output pc, imem_gnt, imem_rvalid, imem_rdata, flush, inst_ready,
        input  pc_stall, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_err
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: issues pc to imem, buffers responses in a 2-entry queue for decode.
// Latency: grant in N, rvalid earliest N+1, inst_valid in N+2; one instruction/cycle sustained.
// Backpressure: no request while queue + outstanding would exceed 2; pc_stall holds the PC.
//
// Ports:
//   clk, rst   clock; asynchronous active-low reset
//   bus        ifetch_if.master (PC/stall, imem handshake, flush, decode queue head)
module ifetch #(
    parameter int WORD_SIZE = 32
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_FAULT} state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] inst;
        logic [WORD_SIZE-1:0] pc;
        logic                 err;
    } entry_t;

    state_t               state_q, state_d;
    logic [1:0]           count_q, count_d;
    entry_t               q0_q, q0_d;      // head entry
    entry_t               q1_q, q1_d;
    logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;

    logic   pop, issue, accept, push;
    logic [2:0] occ;
    entry_t push_ent;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        push_ent = '0;

        pop = (count_q != 2'd0) && bus.inst_ready;
        // Occupancy once this cycle settles: queued + in flight - consumed.
        occ = {1'b0, count_q} + {2'b00, state_q == S_WAIT} - {2'b00, pop};
        // In WAIT a new request may only go out alongside the response that
        // retires the current one, so at most one request is ever outstanding.
        issue = rst && !bus.flush
             && (state_q == S_IDLE || (state_q == S_WAIT && bus.imem_rvalid))
             && (bus.pc[1:0] == 2'b00)
             && (occ <= 3'd1);
        accept = issue && bus.imem_gnt;

        if (accept) begin
            req_pc_d = bus.pc;
        end

        if (bus.flush) begin
            case (state_q)
                S_WAIT:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
                // A response landing in the flush cycle is the one DROP was
                // waiting for; staying in DROP would wait for nothing.
                S_DROP:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_WAIT;
                    end else if (bus.pc[1:0] != 2'b00
                                 && ({1'b0, count_q} - {2'b00, pop}) <= 3'd1) begin
                        push          = 1'b1;
                        push_ent.inst = '0;
                        push_ent.pc   = bus.pc;
                        push_ent.err  = 1'b1;
                        state_d       = S_FAULT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        push          = 1'b1;
                        push_ent.inst = bus.imem_rdata;
                        push_ent.pc   = req_pc_q;
                        push_ent.err  = 1'b0;
                        state_d       = accept ? S_WAIT : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;   // FAULT exits only on flush
            endcase
        end

        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    q0_d    = q1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) q0_d = push_ent;
                    else                 q1_d = push_ent;
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // pop implies count >= 1; the issue rule keeps count <= 2
                    if (count_q == 2'd1) begin
                        q0_d = push_ent;
                    end else begin
                        q0_d = q1_q;
                        q1_d = push_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= 2'd0;
            q0_q     <= '0;
            q1_q     <= '0;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = bus.pc;
    assign bus.pc_stall   = !accept && !bus.flush;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst       = q0_q.inst;
    assign bus.inst_pc    = q0_q.pc;
    assign bus.inst_err   = q0_q.err;

endmodule
